dma_dsc_byp_scheduler: RTL

//  Parametrised XDMA descriptor-bypass front end for NUM_CH independent channels of one direction (instantiated once for C2H, once for H2C).

---
 rtl/dma_dsc_byp_scheduler_pkg.sv | 23 ++
 rtl/dma_dsc_byp_scheduler_if.sv | 33 +++
 rtl/dma_dsc_byp_scheduler_splitter.sv | 132 +++++++++++++
 rtl/dma_dsc_byp_scheduler.sv | 69 ++++++
 4 files changed

// File: rtl/dma_dsc_byp_scheduler_pkg.sv
// Shared FSM type and parameter-legality helpers for the XDMA
// descriptor-bypass scheduler.
package dma_dsc_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } fsm_e;

   localparam logic [31:0] DEF_MAX_CHUNK = 32'h0010_0000;

   // A chunk must be non-empty and representable in the descriptor length field.
   function automatic bit chunk_legal(input longint unsigned max_chunk,
                                      input int unsigned     dsc_len_w);
      return (max_chunk != 0) &&
             ((dsc_len_w >= 64) || (max_chunk < (64'd1 << dsc_len_w)));
   endfunction

   function automatic bit is_pow2(input int unsigned v);
      return (v != 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/dma_dsc_byp_scheduler_if.sv
// Command and XDMA bypass signals for NUM_CH channels of one direction.
interface dma_dsc_byp_scheduler_if #(
   parameter int NUM_CH    = 4,
   parameter int ADDR_W    = 64,
   parameter int LEN_W     = 32,
   parameter int DSC_LEN_W = 28
);
   logic [NUM_CH-1:0]                 s_cmd_valid;
   logic [NUM_CH-1:0]                 s_cmd_ready;
   logic [NUM_CH-1:0][ADDR_W-1:0]     s_cmd_addr;
   logic [NUM_CH-1:0][LEN_W-1:0]      s_cmd_len;
   logic [NUM_CH-1:0]                 halt;
   logic [NUM_CH-1:0]                 dsc_byp_ready;
   logic [NUM_CH-1:0][ADDR_W-1:0]     dsc_byp_addr;
   logic [NUM_CH-1:0][DSC_LEN_W-1:0]  dsc_byp_len;
   logic [NUM_CH-1:0]                 dsc_byp_load;
   logic [NUM_CH-1:0]                 cmd_done;
   logic [NUM_CH-1:0]                 cmd_zero_err;
   logic [NUM_CH-1:0][31:0]           dsc_cnt;
   logic [NUM_CH-1:0]                 busy;

   modport master (
      output s_cmd_valid, s_cmd_addr, s_cmd_len, halt, dsc_byp_ready,
      input  s_cmd_ready, dsc_byp_addr, dsc_byp_len, dsc_byp_load,
             cmd_done, cmd_zero_err, dsc_cnt, busy
   );

   modport slave (
      input  s_cmd_valid, s_cmd_addr, s_cmd_len, halt, dsc_byp_ready,
      output s_cmd_ready, dsc_byp_addr, dsc_byp_len, dsc_byp_load,
             cmd_done, cmd_zero_err, dsc_cnt, busy
   );
endinterface

// File: rtl/dma_dsc_byp_scheduler_splitter.sv
// One bypass channel: command FIFO, descriptor-splitting FSM and load counter.
//  state | meaning
//  IDLE  | no command in progress; pops the FIFO head unless halted
//  ISSUE | presenting cur_q/chunk_q until the last chunk of the command loads
module dma_dsc_splitter
   import dma_dsc_pkg::*;
#(
   parameter int          ADDR_W     = 64,
   parameter int          LEN_W      = 32,
   parameter int          DSC_LEN_W  = 28,
   parameter logic [31:0] MAX_CHUNK  = DEF_MAX_CHUNK,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic                 pcie_clk,
   input  logic                 pcie_rst,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic [ADDR_W-1:0]    cmd_addr_i,
   input  logic [LEN_W-1:0]     cmd_len_i,
   input  logic                 halt_i,
   input  logic                 byp_ready_i,
   output logic [ADDR_W-1:0]    byp_addr_o,
   output logic [DSC_LEN_W-1:0] byp_len_o,
   output logic                 byp_load_o,
   output logic                 done_o,
   output logic                 zero_err_o,
   output logic [31:0]          cnt_o,
   output logic                 busy_o
);
   localparam int             PTR_W   = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};
   localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_CHUNK);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  len;
   } dsc_cmd_t;

   dsc_cmd_t             fifo_q [FIFO_DEPTH];
   logic [PTR_W:0]       wr_ptr_q, rd_ptr_q;
   logic                 full, empty, push, pop;
   dsc_cmd_t             head;
   fsm_e                 state_q, state_d;
   logic [ADDR_W-1:0]    cur_q, cur_d;
   logic [LEN_W-1:0]     rem_q, rem_d, rem_after;
   logic [DSC_LEN_W-1:0] chunk_q, chunk_d;
   logic [31:0]          cnt_q, cnt_d;

   function automatic logic [DSC_LEN_W-1:0] clip(input logic [LEN_W-1:0] r);
      return DSC_LEN_W'((r > MAX_L) ? MAX_L : r);
   endfunction

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign push      = cmd_valid_i & ~full;
   assign head      = fifo_q[rd_ptr_q[PTR_W-1:0]];
   assign rem_after = rem_q - LEN_W'(chunk_q);

   always_ff @(posedge pcie_clk) begin
      if (push) fifo_q[wr_ptr_q[PTR_W-1:0]] <= '{addr: cmd_addr_i, len: cmd_len_i};
   end

   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      rem_d      = rem_q;
      chunk_d    = chunk_q;
      cnt_d      = cnt_q;
      pop        = 1'b0;
      byp_load_o = 1'b0;
      done_o     = 1'b0;
      zero_err_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!empty && !halt_i) begin
               pop = 1'b1;
               if (head.len == '0) begin
                  zero_err_o = 1'b1;
               end else begin
                  cur_d   = head.addr;
                  rem_d   = head.len;
                  chunk_d = clip(head.len);
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (byp_ready_i) begin
               byp_load_o = 1'b1;
               cnt_d      = cnt_q + 32'd1;
               cur_d      = cur_q + ADDR_W'(chunk_q);
               rem_d      = rem_after;
               chunk_d    = clip(rem_after);
               if (rem_after == '0) begin
                  done_o  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pcie_clk or posedge pcie_rst) begin
      if (pcie_rst) begin
         state_q  <= IDLE;
         cur_q    <= '0;
         rem_q    <= '0;
         chunk_q  <= '0;
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         rem_q   <= rem_d;
         chunk_q <= chunk_d;
         cnt_q   <= cnt_d;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   assign cmd_ready_o = ~full;
   assign byp_addr_o  = cur_q;
   assign byp_len_o   = chunk_q;
   assign cnt_o       = cnt_q;
   assign busy_o      = ~empty | (state_q == ISSUE);

endmodule

// File: rtl/dma_dsc_byp_scheduler.sv
// XDMA descriptor-bypass front end: NUM_CH fully independent splitter channels.
module dma_dsc_byp_scheduler
   import dma_dsc_pkg::*;
#(
   parameter int          NUM_CH     = 4,
   parameter int          ADDR_W     = 64,
   parameter int          LEN_W      = 32,
   parameter int          DSC_LEN_W  = 28,
   parameter logic [31:0] MAX_CHUNK  = DEF_MAX_CHUNK,
   parameter int          FIFO_DEPTH = 8
) (
   input logic                    pcie_clk,
   input logic                    pcie_rst,
   dma_dsc_byp_scheduler_if.slave bus
);
   if (!chunk_legal(64'(MAX_CHUNK), DSC_LEN_W)) begin : g_bad_chunk
      $error("MAX_CHUNK must be non-zero and below 2**DSC_LEN_W");
   end
   if (DSC_LEN_W > LEN_W) begin : g_bad_dsc_len
      $error("DSC_LEN_W must not exceed LEN_W");
   end
   if (FIFO_DEPTH < 2 || !is_pow2(FIFO_DEPTH)) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two, at least 2");
   end
   if (NUM_CH < 1 || NUM_CH > 4) begin : g_bad_num_ch
      $error("NUM_CH must be in 1..4");
   end

   logic [NUM_CH-1:0]                cmd_ready, byp_load, done, zero_err, busy;
   logic [NUM_CH-1:0][ADDR_W-1:0]    byp_addr;
   logic [NUM_CH-1:0][DSC_LEN_W-1:0] byp_len;
   logic [NUM_CH-1:0][31:0]          cnt;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      dma_dsc_splitter #(
         .ADDR_W    (ADDR_W),
         .LEN_W     (LEN_W),
         .DSC_LEN_W (DSC_LEN_W),
         .MAX_CHUNK (MAX_CHUNK),
         .FIFO_DEPTH(FIFO_DEPTH)
      ) u_splitter (
         .pcie_clk   (pcie_clk),
         .pcie_rst   (pcie_rst),
         .cmd_valid_i(bus.s_cmd_valid[g]),
         .cmd_ready_o(cmd_ready[g]),
         .cmd_addr_i (bus.s_cmd_addr[g]),
         .cmd_len_i  (bus.s_cmd_len[g]),
         .halt_i     (bus.halt[g]),
         .byp_ready_i(bus.dsc_byp_ready[g]),
         .byp_addr_o (byp_addr[g]),
         .byp_len_o  (byp_len[g]),
         .byp_load_o (byp_load[g]),
         .done_o     (done[g]),
         .zero_err_o (zero_err[g]),
         .cnt_o      (cnt[g]),
         .busy_o     (busy[g])
      );
   end

   assign bus.s_cmd_ready  = cmd_ready;
   assign bus.dsc_byp_addr = byp_addr;
   assign bus.dsc_byp_len  = byp_len;
   assign bus.dsc_byp_load = byp_load;
   assign bus.cmd_done     = done;
   assign bus.cmd_zero_err = zero_err;
   assign bus.dsc_cnt      = cnt;
   assign bus.busy         = busy;

endmodule
